spi_flash_master_gen: RTL

Parametrised SPI flash master (mode 0) that runs one complete flash transaction per accepted request. A frame is command, optional address, programmable dummy cycles, 0..DATA_W/8 write bytes, then 0..DATA_W/8 read bytes. It sits between the CPU-side controller and the SPI flash pins. It is fully synchronous to `clk`: `sclk` is a divided enable-driven output, not a clock domain.

---
 rtl/spi_flash_master_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_flash_master_gen.sv
// SPI flash master, mode 0: one cmd / addr / dummy / write / read frame per accepted request.
// sclk and every pin are flops fed from next-state logic, so the flash sees glitch-free edges.
module spi_flash_master_gen #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int CMD_W   = 8,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = $clog2(DATA_W/8) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic              addr_en,
  input  logic [3:0]        dummy,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic [LEN_W-1:0]  rx_len,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              busy,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);
  localparam int BYTES = DATA_W / 8;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int M1    = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
  localparam int M2    = (M1 > DATA_W) ? M1 : DATA_W;
  localparam int MAXB  = (M2 > 15) ? M2 : 15;
  localparam int CNT_W = $clog2(MAXB + 1);
  localparam int SR_W  = CMD_W + ADDR_W + DATA_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BYTES);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, TX, RX, GUARD} state_t;

  state_t            state, state_d, next_phase;
  logic [DIV_W-1:0]  div, div_d;
  logic [CNT_W-1:0]  cnt, cnt_d, next_cnt;
  logic [SR_W-1:0]   sr, sr_d;
  logic [DATA_W-1:0] rx_sr, rx_sr_d, rx_data_d;
  logic              has_addr, has_addr_d;
  logic [3:0]        dummy_q, dummy_q_d;
  logic [CNT_W-1:0]  tx_bits, tx_bits_d, rx_bits, rx_bits_d;
  logic [LEN_W-1:0]  tx_len_c, rx_len_c;
  logic              bit_end, done_d, sclk_d, ss_d, mosi_d;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    state_d    = state;
    div_d      = div;
    cnt_d      = cnt;
    sr_d       = sr;
    rx_sr_d    = rx_sr;
    rx_data_d  = rx_data;
    has_addr_d = has_addr;
    dummy_q_d  = dummy_q;
    tx_bits_d  = tx_bits;
    rx_bits_d  = rx_bits;
    done_d     = 1'b0;
    bit_end    = (div == DIV_LAST);
    tx_len_c   = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
    rx_len_c   = (rx_len > LEN_MAX) ? LEN_MAX : rx_len;

    // First non-empty phase that follows the current one.
    if (state == CMD && has_addr) begin
      next_phase = ADDR;  next_cnt = CNT_W'(ADDR_W);
    end else if ((state inside {CMD, ADDR}) && dummy_q != 4'd0) begin
      next_phase = DUMMY; next_cnt = CNT_W'(dummy_q);
    end else if ((state inside {CMD, ADDR, DUMMY}) && tx_bits != '0) begin
      next_phase = TX;    next_cnt = tx_bits;
    end else if ((state inside {CMD, ADDR, DUMMY, TX}) && rx_bits != '0) begin
      next_phase = RX;    next_cnt = rx_bits;
    end else begin
      next_phase = GUARD; next_cnt = '0;
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = CMD;
          div_d      = '0;
          cnt_d      = CNT_W'(CMD_W);
          sr_d       = addr_en ? {cmd, addr, tx_data} : {cmd, tx_data, {ADDR_W{1'b0}}};
          rx_sr_d    = '0;
          has_addr_d = addr_en;
          dummy_q_d  = dummy;
          tx_bits_d  = CNT_W'({tx_len_c, 3'b000});
          rx_bits_d  = CNT_W'({rx_len_c, 3'b000});
        end
      end
      GUARD: begin
        div_d = div + 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          div_d   = '0;
        end
      end
      default: begin
        div_d = bit_end ? '0 : div + 1'b1;
        if (state == RX && div == DIV_PRE)
          rx_sr_d = {rx_sr[DATA_W-2:0], miso};
        if (bit_end) begin
          if (state inside {CMD, ADDR, TX})
            sr_d = sr << 1;
          if (cnt == CNT_W'(1)) begin
            state_d = next_phase;
            cnt_d   = next_cnt;
            if (next_phase == GUARD) begin
              done_d = 1'b1;
              // Write-only frames leave the previous read result in place.
              if (rx_bits != '0)
                rx_data_d = rx_sr_d;
            end
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
      end
    endcase

    ss_d   = !(state_d inside {CMD, ADDR, DUMMY, TX, RX});
    sclk_d = !ss_d && (div_d >= DIV_RISE);
    mosi_d = (state_d inside {CMD, ADDR, TX}) ? sr_d[SR_W-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      cnt      <= '0;
      sr       <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      has_addr <= 1'b0;
      dummy_q  <= '0;
      tx_bits  <= '0;
      rx_bits  <= '0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state    <= state_d;
      div      <= div_d;
      cnt      <= cnt_d;
      sr       <= sr_d;
      rx_sr    <= rx_sr_d;
      rx_data  <= rx_data_d;
      has_addr <= has_addr_d;
      dummy_q  <= dummy_q_d;
      tx_bits  <= tx_bits_d;
      rx_bits  <= rx_bits_d;
      done     <= done_d;
      sclk     <= sclk_d;
      ss       <= ss_d;
      mosi     <= mosi_d;
    end
  end
endmodule
